// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multiply/divide unit: operation
//                codes, FSM state encoding and op-class masks.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // Operation codes carried on mdu_op. Codes 13..15 are unused and decode as NONE.
    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;

    // One bit per op code: set when the op belongs to the class.
    // Multiply class: MULT, MULTU, MADD, MADDU, MSUB, MSUBU (bits 1,2,9..12).
    localparam logic [15:0] c_MUL_CLASS = 16'h1E06;
    // Divide class: DIV, DIVU (bits 3,4).
    localparam logic [15:0] c_DIV_CLASS = 16'h0018;

    // Latency counter width; covers the 1..63 latency range.
    localparam int c_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pipe_if
//  Description : Core-to-MDU bus: operation request, operands, busy/stall
//                and move-from-HI/LO read path.
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [3:0]       mdu_op;
    logic             busy;
    logic [WIDTH-1:0] rd_data;
    logic             rd_sel;

    // Core side
    modport master (
        output req, rs_data, rt_data, mdu_op,
        input  busy, rd_data, rd_sel
    );

    // MDU side
    modport slave (
        input  req, rs_data, rt_data, mdu_op,
        output busy, rd_data, rd_sel
    );
endinterface
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational HI/LO calculator. From the captured operands,
//                op and accumulator value it produces the next {HI,LO}.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int c_W2 = 2 * WIDTH;

    logic             w_mul_signed;
    logic             w_div_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [c_W2-1:0]  w_a_ext;
    logic [c_W2-1:0]  w_b_ext;
    logic [c_W2-1:0]  w_prod;
    logic [c_W2-1:0]  w_acc;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    // Multiply: extend both operands to 2*WIDTH so the truncated product is
    // exact for both signed and unsigned interpretations.
    assign w_mul_signed = (i_op == c_OP_MULT) | (i_op == c_OP_MADD) | (i_op == c_OP_MSUB);
    assign w_a_ext = w_mul_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    assign w_b_ext = w_mul_signed ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_acc   = {i_hi, i_lo};

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. Most-negative / -1 needs no
    // special case: its magnitude 2^(WIDTH-1) divided by 1 re-encodes as the
    // most-negative value with a zero remainder.
    assign w_div_signed = (i_op == c_OP_DIV);
    assign w_a_neg = w_div_signed & i_a[WIDTH-1];
    assign w_b_neg = w_div_signed & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_q     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_r     = w_a_neg ? -w_r_mag : w_r_mag;

    // Select the result for the captured op; unknown ops keep HI/LO.
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        case (i_op)
            c_OP_MULT, c_OP_MULTU: {o_hi, o_lo} = w_prod;
            c_OP_MADD, c_OP_MADDU: {o_hi, o_lo} = w_acc + w_prod;
            c_OP_MSUB, c_OP_MSUBU: {o_hi, o_lo} = w_acc - w_prod;
            c_OP_DIV,  c_OP_DIVU: begin
                if (i_b == '0) begin
                    // Divide by zero does not trap: all-ones quotient, dividend as remainder.
                    o_lo = '1;
                    o_hi = i_a;
                end else begin
                    o_lo = w_q;
                    o_hi = w_r;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pipe
//  Description : Multi-cycle multiply/divide unit with HI/LO registers.
//                Fixed-latency FSM; result computed by mdu_arith from
//                operands captured at start and committed on the last cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_pipe
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_pipe_if.slave  bus
);

    mdu_state_e         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi_acc;
    logic [WIDTH-1:0]   r_lo_acc;
    logic [3:0]         r_op;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_start_req;
    logic               w_idle;
    logic               w_start;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;

    assign w_is_mul    = c_MUL_CLASS[bus.mdu_op];
    assign w_is_div    = c_DIV_CLASS[bus.mdu_op];
    assign w_start_req = (w_is_mul | w_is_div) & ~bus.req;
    assign w_idle      = (r_state == ST_IDLE);
    assign w_start     = w_start_req & w_idle;

    // Busy covers the issue cycle combinationally so the core stalls at once.
    assign bus.busy    = w_start_req | ~w_idle;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_hi (r_hi_acc),
        .i_lo (r_lo_acc),
        .o_hi (w_hi_nxt),
        .o_lo (w_lo_nxt)
    );

    // FSM, latency counter, operand capture and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
            r_op     <= c_OP_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_a      <= bus.rs_data;
                        r_b      <= bus.rt_data;
                        r_hi_acc <= r_hi;
                        r_lo_acc <= r_lo;
                        r_op     <= bus.mdu_op;
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                            r_cnt   <= c_CNT_W'(MUL_LAT);
                        end else begin
                            r_state <= ST_DIV;
                            r_cnt   <= c_CNT_W'(DIV_LAT);
                        end
                    end else if (!bus.req && bus.mdu_op == c_OP_MTHI) begin
                        r_hi <= bus.rs_data;
                    end else if (!bus.req && bus.mdu_op == c_OP_MTLO) begin
                        r_lo <= bus.rs_data;
                    end
                end
                ST_MUL, ST_DIV: begin
                    // New requests and req are ignored until the operation commits.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_hi    <= w_hi_nxt;
                        r_lo    <= w_lo_nxt;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Move-from read path straight off the HI/LO registers.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_sel  = 1'b0;
        if (bus.mdu_op == c_OP_MFHI) begin
            bus.rd_data = r_hi;
            bus.rd_sel  = 1'b1;
        end else if (bus.mdu_op == c_OP_MFLO) begin
            bus.rd_data = r_lo;
            bus.rd_sel  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_pipe
//  Description : Directed self-checking bench for mdu_pipe with
//                hand-computed HI/LO results and busy timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_pipe;
    import mdu_pkg::*;

    localparam int c_MUL_LAT = 5;
    localparam int c_DIV_LAT = 10;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mdu_pipe_if #(.WIDTH(32)) bus ();

    mdu_pipe #(
        .WIDTH   (32),
        .MUL_LAT (c_MUL_LAT),
        .DIV_LAT (c_DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_hilo(output logic [31:0] hi, output logic [31:0] lo);
        bus.mdu_op = c_OP_MFHI;
        #1 hi = bus.rd_data;
        bus.mdu_op = c_OP_MFLO;
        #1 lo = bus.rd_data;
        bus.mdu_op = c_OP_NONE;
        #1;
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
        logic [31:0] h, l;
        rd_hilo(h, l);
        chk({tag, "_hi"}, {32'h0, h}, {32'h0, e_hi});
        chk({tag, "_lo"}, {32'h0, l}, {32'h0, e_lo});
    endtask

    // Issue a multiply/divide op, count busy cycles, check the pre-commit HI
    // in the last busy cycle and the committed HI/LO afterwards.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] old_hi, input bit req_mid,
                          input logic [31:0] e_hi, input logic [31:0] e_lo);
        int n;
        bus.mdu_op  = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.req     = 1'b0;
        #1 chk({tag, "_busy_start"}, {63'h0, bus.busy}, 64'd1);
        step();
        bus.mdu_op = c_OP_NONE;
        bus.req    = req_mid;
        n = 1;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            n++;
            if (n == lat + 1) begin
                bus.mdu_op = c_OP_MFHI;
                #1 chk({tag, "_pre_commit_hi"}, {32'h0, bus.rd_data}, {32'h0, old_hi});
                bus.mdu_op = c_OP_NONE;
            end
            step();
            bus.req = 1'b0;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(lat + 1));
        chk_hilo(tag, e_hi, e_lo);
    endtask

    // Single-cycle op that must not raise busy (MTHI/MTLO, suppressed ops).
    task automatic issue1(input logic [3:0] op, input logic [31:0] a, input logic reqv);
        bus.mdu_op  = op;
        bus.rs_data = a;
        bus.rt_data = 32'h0;
        bus.req     = reqv;
        step();
        bus.mdu_op  = c_OP_NONE;
        bus.req     = 1'b0;
    endtask

    initial begin
        int e;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        bus.req     = 1'b0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.mdu_op  = c_OP_NONE;
        repeat (3) step();
        reset = 1'b1;

        // Reset state
        #1;
        chk("rst_busy",   {63'h0, bus.busy},   64'd0);
        chk("rst_rd_sel", {63'h0, bus.rd_sel}, 64'd0);
        chk("rst_rd_data", {32'h0, bus.rd_data}, 64'd0);
        chk_hilo("rst", 32'h0, 32'h0);
        bus.mdu_op = c_OP_MFHI;
        #1 chk("mfhi_rd_sel", {63'h0, bus.rd_sel}, 64'd1);
        bus.mdu_op = c_OP_MULT;
        #1 chk("mult_rd_data_zero", {32'h0, bus.rd_data}, 64'd0);
        chk("mult_rd_sel_zero", {63'h0, bus.rd_sel}, 64'd0);
        bus.mdu_op = c_OP_NONE;
        step();

        // Multiply
        run_op("mult",  c_OP_MULT,  32'hFFFFFFFE, 32'd3, c_MUL_LAT, 32'h0,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", c_OP_MULTU, 32'hFFFFFFFE, 32'd3, c_MUL_LAT, 32'hFFFFFFFF, 1'b1, 32'h00000002, 32'hFFFFFFFA);

        // Divide
        run_op("div_m7_2",    c_OP_DIV,  32'hFFFFFFF9, 32'd2,        c_DIV_LAT, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by0",    c_OP_DIVU, 32'd7,        32'd0,        c_DIV_LAT, 32'hFFFFFFFF, 1'b0, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_ovf",     c_OP_DIV,  32'h80000000, 32'hFFFFFFFF, c_DIV_LAT, 32'h00000007, 1'b0, 32'h00000000, 32'h80000000);
        run_op("div_7_m2",    c_OP_DIV,  32'd7,        32'hFFFFFFFE, c_DIV_LAT, 32'h00000000, 1'b0, 32'h00000001, 32'hFFFFFFFD);
        run_op("div_m5_by0",  c_OP_DIV,  32'hFFFFFFFB, 32'd0,        c_DIV_LAT, 32'h00000001, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Move-to and accumulate
        bus.mdu_op = c_OP_MTHI;
        #1 chk("mthi_busy", {63'h0, bus.busy}, 64'd0);
        issue1(c_OP_MTHI, 32'h0, 1'b0);
        issue1(c_OP_MTLO, 32'hFFFFFFFF, 1'b0);
        chk_hilo("mt", 32'h0, 32'hFFFFFFFF);
        run_op("maddu", c_OP_MADDU, 32'd1,        32'd1, c_MUL_LAT, 32'h0, 1'b0, 32'h00000001, 32'h00000000);
        run_op("msub",  c_OP_MSUB,  32'd1,        32'd1, c_MUL_LAT, 32'h1, 1'b0, 32'h00000000, 32'hFFFFFFFF);
        run_op("madd",  c_OP_MADD,  32'hFFFFFFFF, 32'd2, c_MUL_LAT, 32'h0, 1'b0, 32'h00000000, 32'hFFFFFFFD);
        run_op("msubu", c_OP_MSUBU, 32'hFFFFFFFF, 32'd2, c_MUL_LAT, 32'h0, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF);

        // Suppression by req and unused op codes
        bus.mdu_op = c_OP_MULT;
        bus.req    = 1'b1;
        #1 chk("req_mult_busy_now", {63'h0, bus.busy}, 64'd0);
        issue1(c_OP_MULT, 32'd5, 1'b1);
        chk("req_mult_busy_next", {63'h0, bus.busy}, 64'd0);
        step();
        chk("req_mult_busy_later", {63'h0, bus.busy}, 64'd0);
        chk_hilo("req_mult", 32'hFFFFFFFE, 32'hFFFFFFFF);
        issue1(c_OP_MTHI, 32'h1234, 1'b1);
        chk_hilo("req_mthi", 32'hFFFFFFFE, 32'hFFFFFFFF);
        bus.mdu_op = 4'd13;
        #1 chk("op13_busy", {63'h0, bus.busy}, 64'd0);
        chk("op13_rd_sel", {63'h0, bus.rd_sel}, 64'd0);
        issue1(4'd13, 32'h55, 1'b0);
        chk("op13_busy_next", {63'h0, bus.busy}, 64'd0);
        chk_hilo("op13", 32'hFFFFFFFE, 32'hFFFFFFFF);

        // Ops issued while busy are dropped; the divide still commits on time
        bus.mdu_op  = c_OP_DIV;
        bus.rs_data = 32'd100;
        bus.rt_data = 32'd7;
        step();
        bus.mdu_op  = c_OP_MTLO;
        bus.rs_data = 32'd5;
        step();
        bus.mdu_op  = c_OP_MULT;
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd3;
        step();
        bus.mdu_op  = c_OP_NONE;
        e = 3;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            step();
            e++;
        end
        chk("busy_ign_edges", 64'(e), 64'(c_DIV_LAT + 1));
        chk_hilo("busy_ign", 32'd2, 32'd14);
        repeat (8) step();
        chk("busy_ign_no_restart", {63'h0, bus.busy}, 64'd0);
        chk_hilo("busy_ign_late", 32'd2, 32'd14);

        // Reset in the middle of a multiply aborts it
        bus.mdu_op  = c_OP_MULT;
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd5;
        step();
        bus.mdu_op  = c_OP_NONE;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_mid_busy", {63'h0, bus.busy}, 64'd0);
        chk_hilo("rst_mid", 32'h0, 32'h0);
        repeat (8) step();
        chk("rst_mid_busy_late", {63'h0, bus.busy}, 64'd0);
        chk_hilo("rst_mid_late", 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
